// File: rtl/alu_operand_loader.sv
// Operator front end for the board ALU: loads A, B and opcode from the switches on debounced
// button presses, captures the ALU result for the LEDs and rejects unsupported opcodes.
module alu_operand_loader #(
  parameter int unsigned N_BITS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] sw,
  input  logic              btn,
  input  logic [N_BITS-1:0] alu_out,
  output logic [N_BITS-1:0] d0,
  output logic [N_BITS-1:0] d1,
  output logic [5:0]        opcode,
  output logic [N_BITS-1:0] result,
  output logic              valid,
  output logic              op_err,
  output logic [2:0]        state
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    StLoadA  = 3'd0,
    StLoadB  = 3'd1,
    StLoadOp = 3'd2,
    StExec   = 3'd3,
    StShow   = 3'd4
  } state_e;

  state_e          state_q;
  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q;
  logic            stable_q;
  logic            edge_q;
  logic            press;
  logic            op_ok;

  // Button conditioning: the stable level only follows the synchronized level after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles, so both press and release are filtered.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      edge_q  <= stable_q;
      if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else if (sync2_q != stable_q) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press = stable_q & ~edge_q;

  always_comb begin
    op_ok = 1'b0;
    case (sw[5:0])
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b000011, 6'b000010, 6'b100111: op_ok = 1'b1;
      default:                                    op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoadA;
      d0      <= '0;
      d1      <= '0;
      opcode  <= 6'b000000;
      result  <= '0;
      valid   <= 1'b0;
      op_err  <= 1'b0;
    end else begin
      unique case (state_q)
        StLoadA: begin
          if (press) begin
            d0      <= sw;
            state_q <= StLoadB;
          end
        end
        StLoadB: begin
          if (press) begin
            d1      <= sw;
            state_q <= StLoadOp;
          end
        end
        StLoadOp: begin
          if (press) begin
            if (op_ok) begin
              opcode  <= sw[5:0];
              op_err  <= 1'b0;
              state_q <= StExec;
            end else begin
              op_err <= 1'b1;
            end
          end
        end
        // ALU output settles from the registered opcode before this edge.
        StExec: begin
          result  <= alu_out;
          valid   <= 1'b1;
          state_q <= StShow;
        end
        StShow: begin
          if (press) begin
            valid   <= 1'b0;
            state_q <= StLoadA;
          end
        end
        default: state_q <= StLoadA;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader with a behavioural ALU stand-in and a result scoreboard.
module tb_alu_operand_loader;

  localparam int unsigned NB = 8;

  logic          clk;
  logic          reset;
  logic [NB-1:0] sw;
  logic          btn;
  logic [NB-1:0] alu_out;
  logic [NB-1:0] d0, d1, result;
  logic [5:0]    opcode;
  logic          valid, op_err;
  logic [2:0]    state;

  int            checks;
  int            errors;
  int            press_cnt;
  logic          valid_prev;
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] exp_v;

  alu_operand_loader #(
    .N_BITS         (NB),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .btn    (btn),
    .alu_out(alu_out),
    .d0     (d0),
    .d1     (d1),
    .opcode (opcode),
    .result (result),
    .valid  (valid),
    .op_err (op_err),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    case (opcode)
      6'b100000: alu_out = d0 + d1;
      6'b100010: alu_out = d0 - d1;
      6'b100100: alu_out = d0 & d1;
      6'b100101: alu_out = d0 | d1;
      6'b100110: alu_out = d0 ^ d1;
      6'b000011: alu_out = NB'($signed(d0) >>> d1);
      6'b000010: alu_out = d0 >> d1;
      6'b100111: alu_out = ~(d0 | d1);
      default:   alu_out = '0;
    endcase
  end

  // Monitor: valid must still be low during EXEC; each rising valid pops one expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (dut.press) press_cnt++;
      if (state == 3'd3) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL exec_valid_early got %b want 0", valid);
        end
      end
      if (valid && !valid_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected result %0d with empty scoreboard", result);
        end else begin
          exp_v = exp_q.pop_front();
          if (result !== exp_v) begin
            errors++;
            $display("FAIL sb_result got %0d want %0d", result, exp_v);
          end
        end
      end
    end
    valid_prev = valid;
  end

  task automatic press_btn(input logic [NB-1:0] val, input int hold);
    @(negedge clk);
    sw  = val;
    btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset(3);
    checks += 7;
    if (d0 !== 8'd0)      begin errors++; $display("FAIL reset_d0 got %0d want 0", d0); end
    if (d1 !== 8'd0)      begin errors++; $display("FAIL reset_d1 got %0d want 0", d1); end
    if (result !== 8'd0)  begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    if (opcode !== 6'd0)  begin errors++; $display("FAIL reset_opcode got %b want 0", opcode); end
    if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    if (op_err !== 1'b0)  begin errors++; $display("FAIL reset_op_err got %b want 0", op_err); end
    if (state !== 3'd0)   begin errors++; $display("FAIL reset_state got %0d want 0", state); end
  endtask

  task automatic test_add;
    press_btn(8'd1, 10);
    press_btn(8'd1, 10);
    exp_q.push_back(8'd2);
    press_btn(8'h20, 10);
    checks += 5;
    if (d0 !== 8'd1)          begin errors++; $display("FAIL add_d0 got %0d want 1", d0); end
    if (d1 !== 8'd1)          begin errors++; $display("FAIL add_d1 got %0d want 1", d1); end
    if (opcode !== 6'b100000) begin errors++; $display("FAIL add_opcode got %b want 100000", opcode); end
    if (valid !== 1'b1)       begin errors++; $display("FAIL add_valid got %b want 1", valid); end
    if (state !== 3'd4)       begin errors++; $display("FAIL add_state got %0d want 4", state); end
  endtask

  task automatic test_bad_opcode;
    press_btn(8'd0, 10);
    press_btn(8'd4, 10);
    press_btn(8'd1, 10);
    press_btn(8'h3F, 10);
    checks += 3;
    if (op_err !== 1'b1)      begin errors++; $display("FAIL bad_op_err got %b want 1", op_err); end
    if (state !== 3'd2)       begin errors++; $display("FAIL bad_op_state got %0d want 2", state); end
    if (opcode !== 6'b100000) begin errors++; $display("FAIL bad_op_opcode got %b want 100000", opcode); end
    exp_q.push_back(8'd3);
    press_btn(8'h22, 10);
    checks += 4;
    if (op_err !== 1'b0)      begin errors++; $display("FAIL sub_op_err got %b want 0", op_err); end
    if (opcode !== 6'b100010) begin errors++; $display("FAIL sub_opcode got %b want 100010", opcode); end
    if (valid !== 1'b1)       begin errors++; $display("FAIL sub_valid got %b want 1", valid); end
    if (state !== 3'd4)       begin errors++; $display("FAIL sub_state got %0d want 4", state); end
  endtask

  task automatic test_debounce;
    press_btn(8'd0, 10);
    press_cnt = 0;
    press_btn(8'd9, 2);
    press_btn(8'd9, 3);
    checks += 2;
    if (state !== 3'd0)  begin errors++; $display("FAIL glitch_state got %0d want 0", state); end
    if (press_cnt !== 0) begin errors++; $display("FAIL glitch_press got %0d want 0", press_cnt); end
    press_btn(8'd9, 10);
    checks += 3;
    if (state !== 3'd1)  begin errors++; $display("FAIL held_state got %0d want 1", state); end
    if (press_cnt !== 1) begin errors++; $display("FAIL held_press got %0d want 1", press_cnt); end
    if (d0 !== 8'd9)     begin errors++; $display("FAIL held_d0 got %0d want 9", d0); end
  endtask

  task automatic test_reset_mid;
    do_reset(1);
    press_btn(8'd12, 10);
    press_btn(8'd1, 10);
    checks += 1;
    if (state !== 3'd2) begin errors++; $display("FAIL mid_pre_state got %0d want 2", state); end
    do_reset(1);
    checks += 5;
    if (state !== 3'd0)  begin errors++; $display("FAIL mid_state got %0d want 0", state); end
    if (d0 !== 8'd0)     begin errors++; $display("FAIL mid_d0 got %0d want 0", d0); end
    if (d1 !== 8'd0)     begin errors++; $display("FAIL mid_d1 got %0d want 0", d1); end
    if (valid !== 1'b0)  begin errors++; $display("FAIL mid_valid got %b want 0", valid); end
    if (result !== 8'd0) begin errors++; $display("FAIL mid_result got %0d want 0", result); end
  endtask

  task automatic test_show_return;
    press_btn(8'd12, 10);
    press_btn(8'd1, 10);
    exp_q.push_back(8'd6);
    press_btn(8'h03, 10);
    checks += 2;
    if (state !== 3'd4) begin errors++; $display("FAIL sra_state got %0d want 4", state); end
    if (valid !== 1'b1) begin errors++; $display("FAIL sra_valid got %b want 1", valid); end
    press_btn(8'd0, 10);
    checks += 4;
    if (valid !== 1'b0)       begin errors++; $display("FAIL ret_valid got %b want 0", valid); end
    if (state !== 3'd0)       begin errors++; $display("FAIL ret_state got %0d want 0", state); end
    if (result !== 8'd6)      begin errors++; $display("FAIL ret_result got %0d want 6", result); end
    if (opcode !== 6'b000011) begin errors++; $display("FAIL ret_opcode got %b want 000011", opcode); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    press_cnt  = 0;
    valid_prev = 1'b0;
    reset      = 1'b1;
    btn        = 1'b0;
    sw         = '0;
    test_reset();
    test_add();
    test_bad_opcode();
    test_debounce();
    test_reset_mid();
    test_show_return();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
